// File: rtl/lcd_pkg.sv
// ----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the AHB character-LCD controller:
//   - register offsets (HADDR[3:2] encoding)
//   - engine state codes
//   - STATUS register bit positions
//   - HD44780 clear/home opcodes, which need the long settle time
//   - the queued entry layout {isData, data}
// ----------------------------------------------------------------------------
package lcd_pkg;

  // Register offsets as seen on HADDR[3:2]
  localparam logic [1:0] REG_CMD    = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_TIMING = 2'd3;

  // Engine state codes
  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_SETUP  = 4'd1;
  localparam logic [3:0] ST_LOAD_H = 4'd2;
  localparam logic [3:0] ST_EH_H   = 4'd3;
  localparam logic [3:0] ST_EL_H   = 4'd4;
  localparam logic [3:0] ST_LOAD_L = 4'd5;
  localparam logic [3:0] ST_EH_L   = 4'd6;
  localparam logic [3:0] ST_EL_L   = 4'd7;
  localparam logic [3:0] ST_WAIT   = 4'd8;

  // STATUS register layout
  localparam int STAT_BUSY      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_FULL      = 2;
  localparam int STAT_COUNT_LSB = 16;

  // Commands that make the LCD controller busy for milliseconds
  localparam logic [7:0] OP_CLEAR = 8'h01;
  localparam logic [7:0] OP_HOME  = 8'h02;

  // One queued LCD transaction
  typedef struct packed {
    logic       isData;
    logic [7:0] data;
  } lcdEntry_t;

  localparam int ENTRY_W = $bits(lcdEntry_t);

  // True when the entry is a clear/home command and needs the long settle
  function automatic logic isLongOp(input lcdEntry_t entry);
    return !entry.isData && ((entry.data == OP_CLEAR) || (entry.data == OP_HOME));
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// ----------------------------------------------------------------------------
// lcd_cmd_fifo
// Synchronous FIFO holding queued LCD entries. Head of queue is presented
// combinationally on rdata_o. Push while full and pop while empty are
// ignored; push and pop in the same cycle leave the count unchanged.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset (flushes FIFO)
//   push_i, wdata_i    write request and entry
//   pop_i              remove head entry
//   rdata_o            head entry
//   full_o, empty_o    occupancy flags
//   count_o            number of stored entries (0..DEPTH)
// ----------------------------------------------------------------------------
module lcd_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [AW:0]      count_q, count_d;
  logic             doPush, doPop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem[rdPtr_q];

  assign doPush = push_i && !full_o;
  assign doPop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (doPop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    case ({doPush, doPop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid
  always_ff @(posedge clk_i) begin
    if (doPush) begin
      mem[wrPtr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/ahb_lcd_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// ahb_lcd_fifo_ctrl
// AHB-Lite slave driving an HD44780-class character LCD. CMD/DATA writes are
// queued; a timed engine replays each entry as 4-bit (two nibbles, high first)
// or 8-bit bus cycles followed by a settle delay (long after clear/home).
// Ports:
//   HCLK, HRESETn             clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS,      AHB-Lite address phase (only HADDR[3:2] used)
//   HWRITE, HREADY
//   HWDATA                    write data (data phase)
//   HREADYOUT                 low while a CMD/DATA write waits on a full FIFO
//   HRDATA                    read data (STATUS, TIMING; others read 0)
//   LCD_RS, LCD_RW, LCD_E     LCD control lines (RW tied low)
//   LCD_DB                    LCD data bus, DB_W bits
// Registers: 0x00 CMD (W), 0x04 DATA (W), 0x08 STATUS (R),
//            0x0C TIMING (R/W, HCLK cycles per engine step, 0 stored as 1)
// ----------------------------------------------------------------------------
module ahb_lcd_fifo_ctrl
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int DB_W         = 4,
  parameter int STEP_DEFAULT = 50,
  parameter int SHORT_WAIT   = 2000,
  parameter int LONG_WAIT    = 80000,
  parameter int CNT_W        = 20
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic            HSEL,
  input  logic [31:0]     HADDR,
  input  logic [1:0]      HTRANS,
  input  logic            HWRITE,
  input  logic [31:0]     HWDATA,
  input  logic            HREADY,
  output logic            HREADYOUT,
  output logic [31:0]     HRDATA,
  output logic            LCD_RS,
  output logic            LCD_RW,
  output logic            LCD_E,
  output logic [DB_W-1:0] LCD_DB
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // AHB data-phase context
  logic       dpValid_q;
  logic       dpWrite_q;
  logic [1:0] dpAddr_q;

  // Register state
  logic [15:0] timing_q;

  // FIFO interface
  logic               fifoPush, fifoPop;
  logic               fifoFull, fifoEmpty;
  logic [CW-1:0]      fifoCount;
  logic [ENTRY_W-1:0] fifoRdata;
  lcdEntry_t          pushEntry, headEntry;

  // Engine state
  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      stepLen_q, stepLen_d;
  lcdEntry_t        entry_q, entry_d;
  logic             rs_q, rs_d;
  logic             e_q, e_d;
  logic [DB_W-1:0]  db_q, db_d;

  logic             dpFifoWr, dpTimingWr, busy;
  logic [CNT_W-1:0] stepLast, waitLast;
  logic [DB_W-1:0]  dbHigh, dbLow;
  logic [31:0]      statusWord;
  logic             unusedBits;

  assign unusedBits = ^{HADDR[31:4], HADDR[1:0], HWDATA[31:16], HTRANS[0]};

  // Capture the address phase; while the bus is stalled the pending data
  // phase is held so the write completes once a FIFO slot frees up.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dpValid_q <= 1'b0;
      dpWrite_q <= 1'b0;
      dpAddr_q  <= 2'd0;
    end else if (HREADY) begin
      dpValid_q <= HSEL && HTRANS[1];
      dpWrite_q <= HWRITE;
      dpAddr_q  <= HADDR[3:2];
    end
  end

  assign dpFifoWr   = dpValid_q && dpWrite_q &&
                      ((dpAddr_q == REG_CMD) || (dpAddr_q == REG_DATA));
  assign dpTimingWr = dpValid_q && dpWrite_q && (dpAddr_q == REG_TIMING);

  // Only a queue write that finds the FIFO full stalls the bus
  assign HREADYOUT = !(dpFifoWr && fifoFull);
  assign fifoPush  = dpFifoWr && !fifoFull;

  assign pushEntry.isData = (dpAddr_q == REG_DATA);
  assign pushEntry.data   = HWDATA[7:0];

  // A zero step length would never expire, so it is promoted to one
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      timing_q <= 16'(STEP_DEFAULT);
    end else if (dpTimingWr) begin
      timing_q <= (HWDATA[15:0] == 16'd0) ? 16'd1 : HWDATA[15:0];
    end
  end

  assign busy = (state_q != ST_IDLE) || !fifoEmpty;

  always_comb begin
    statusWord = '0;
    statusWord[STAT_COUNT_LSB +: 16] = {{(16-CW){1'b0}}, fifoCount};
    statusWord[STAT_FULL]  = fifoFull;
    statusWord[STAT_EMPTY] = fifoEmpty;
    statusWord[STAT_BUSY]  = busy;
  end

  // Read data is driven only during a read data phase
  always_comb begin
    HRDATA = '0;
    if (dpValid_q && !dpWrite_q) begin
      case (dpAddr_q)
        REG_STATUS: HRDATA = statusWord;
        REG_TIMING: HRDATA = {16'd0, timing_q};
        default:    HRDATA = '0;
      endcase
    end
  end

  lcd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (HCLK),
    .rst_ni  (HRESETn),
    .push_i  (fifoPush),
    .wdata_i (pushEntry),
    .pop_i   (fifoPop),
    .rdata_o (fifoRdata),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  assign headEntry = lcdEntry_t'(fifoRdata);

  // In 8-bit mode the whole byte goes out in the "high" transfer
  assign dbHigh = (DB_W == 8) ? DB_W'(entry_q.data) : DB_W'(entry_q.data[7:4]);
  assign dbLow  = DB_W'(entry_q.data[3:0]);

  assign stepLast = CNT_W'(stepLen_q) - 1'b1;
  assign waitLast = isLongOp(entry_q) ? CNT_W'(LONG_WAIT - 1) : CNT_W'(SHORT_WAIT - 1);

  // Engine: outputs change as a state is entered, so E is high exactly for
  // the EH_* states. The step length is resampled from TIMING at every
  // step boundary, so a TIMING write never cuts a running step short.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stepLen_d = stepLen_q;
    entry_d   = entry_q;
    rs_d      = rs_q;
    e_d       = e_q;
    db_d      = db_q;
    fifoPop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!fifoEmpty) begin
          fifoPop   = 1'b1;
          entry_d   = headEntry;
          rs_d      = headEntry.isData;
          stepLen_d = timing_q;
          state_d   = ST_SETUP;
        end
      end
      ST_WAIT: begin
        if (cnt_q >= waitLast) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SETUP, ST_LOAD_H, ST_EH_H, ST_EL_H, ST_LOAD_L, ST_EH_L, ST_EL_L: begin
        if (cnt_q >= stepLast) begin
          cnt_d     = '0;
          stepLen_d = timing_q;
          case (state_q)
            ST_SETUP: begin
              db_d    = dbHigh;
              state_d = ST_LOAD_H;
            end
            ST_LOAD_H: begin
              e_d     = 1'b1;
              state_d = ST_EH_H;
            end
            ST_EH_H: begin
              e_d     = 1'b0;
              state_d = ST_EL_H;
            end
            ST_EL_H: begin
              if (DB_W == 4) begin
                db_d    = dbLow;
                state_d = ST_LOAD_L;
              end else begin
                state_d = ST_WAIT;
              end
            end
            ST_LOAD_L: begin
              e_d     = 1'b1;
              state_d = ST_EH_L;
            end
            ST_EH_L: begin
              e_d     = 1'b0;
              state_d = ST_EL_L;
            end
            default: begin
              state_d = ST_WAIT;
            end
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        e_d     = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      stepLen_q <= 16'd1;
      entry_q   <= '0;
      rs_q      <= 1'b0;
      e_q       <= 1'b0;
      db_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stepLen_q <= stepLen_d;
      entry_q   <= entry_d;
      rs_q      <= rs_d;
      e_q       <= e_d;
      db_q      <= db_d;
    end
  end

  assign LCD_RS = rs_q;
  assign LCD_RW = 1'b0;
  assign LCD_E  = e_q;
  assign LCD_DB = db_q;

endmodule

// File: tb/tb_ahb_lcd_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ahb_lcd_fifo_ctrl
// Scoreboard bench for ahb_lcd_fifo_ctrl. Two instances share the AHB bus
// (4-bit and 8-bit LCD builds, selected by separate HSEL lines). Writes to
// CMD/DATA queue the expected LCD strobes; a monitor per instance checks
// RS/DB/E-width (and minimum idle gap) on every E pulse. Reads queue the
// expected HRDATA; a read monitor checks it when the data phase completes.
// ----------------------------------------------------------------------------
module tb_ahb_lcd_fifo_ctrl;

  localparam int CLK_P   = 10;
  localparam int DEPTH   = 8;
  localparam int T_SHORT = 20;
  localparam int T_LONG  = 200;

  typedef struct {
    logic       rs;
    logic [7:0] db;
    int         width;
    int         minGap;
  } pulse_t;

  logic        HCLK    = 1'b0;
  logic        HRESETn = 1'b0;
  logic        sel4, sel8;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic        rdy4, rdy8;
  logic [31:0] rdata4, rdata8;
  logic        rs4, rw4, e4, rs8, rw8, e8;
  logic [3:0]  db4;
  logic [7:0]  db8;

  int compared   = 0;
  int mismatched = 0;
  int tim4 = 50;
  int tim8 = 50;

  pulse_t      expQ4[$];
  pulse_t      expQ8[$];
  logic [31:0] rdExpQ[$];
  string       rdNameQ[$];

  always #(CLK_P/2) HCLK = ~HCLK;

  // Single-master system: the bus ready is the AND of both slaves
  assign HREADY = rdy4 & rdy8;

  ahb_lcd_fifo_ctrl #(
    .FIFO_DEPTH(DEPTH), .DB_W(4), .STEP_DEFAULT(50),
    .SHORT_WAIT(T_SHORT), .LONG_WAIT(T_LONG), .CNT_W(20)
  ) dut4 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel4), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(rdy4), .HRDATA(rdata4), .LCD_RS(rs4), .LCD_RW(rw4),
    .LCD_E(e4), .LCD_DB(db4)
  );

  ahb_lcd_fifo_ctrl #(
    .FIFO_DEPTH(DEPTH), .DB_W(8), .STEP_DEFAULT(50),
    .SHORT_WAIT(T_SHORT), .LONG_WAIT(T_LONG), .CNT_W(20)
  ) dut8 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel8), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(rdy8), .HRDATA(rdata8), .LCD_RS(rs8), .LCD_RW(rw8),
    .LCD_E(e8), .LCD_DB(db8)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkAtLeast(input string name, input int act, input int minVal);
    compared++;
    if (act < minVal) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d cycles, expected at least %0d", name, act, minVal);
    end
  endtask

  // LCD monitor, 4-bit instance
  time    riseT4 = 0, fallT4 = 0;
  int     rise4 = 0, fall4 = 0;
  logic   capRs4;
  logic [7:0] capDb4;
  pulse_t p4;

  always @(posedge e4) begin
    rise4++;
    capRs4 = rs4;
    capDb4 = {4'h0, db4};
    riseT4 = $time;
    if (expQ4.size() > 0 && expQ4[0].minGap > 0)
      checkAtLeast("gap4", int'((riseT4 - fallT4) / CLK_P), expQ4[0].minGap);
  end

  always @(negedge e4) begin
    if (!HRESETn) begin
      if (expQ4.size() > 0) p4 = expQ4.pop_front();
    end else begin
      fall4++;
      fallT4 = $time;
      if (expQ4.size() == 0) begin
        checkOutput("unexpectedPulse4", {24'h0, capDb4}, 32'hFFFF_FFFF);
      end else begin
        p4 = expQ4.pop_front();
        checkOutput("rs4", {31'h0, capRs4}, {31'h0, p4.rs});
        checkOutput("db4", {24'h0, capDb4}, {24'h0, p4.db});
        checkOutput("eWidth4", int'((fallT4 - riseT4) / CLK_P), p4.width);
      end
    end
  end

  // LCD monitor, 8-bit instance
  time    riseT8 = 0, fallT8 = 0;
  int     fall8 = 0;
  logic   capRs8;
  logic [7:0] capDb8;
  pulse_t p8;

  always @(posedge e8) begin
    capRs8 = rs8;
    capDb8 = db8;
    riseT8 = $time;
    if (expQ8.size() > 0 && expQ8[0].minGap > 0)
      checkAtLeast("gap8", int'((riseT8 - fallT8) / CLK_P), expQ8[0].minGap);
  end

  always @(negedge e8) begin
    if (!HRESETn) begin
      if (expQ8.size() > 0) p8 = expQ8.pop_front();
    end else begin
      fall8++;
      fallT8 = $time;
      if (expQ8.size() == 0) begin
        checkOutput("unexpectedPulse8", {24'h0, capDb8}, 32'hFFFF_FFFF);
      end else begin
        p8 = expQ8.pop_front();
        checkOutput("rs8", {31'h0, capRs8}, {31'h0, p8.rs});
        checkOutput("db8", {24'h0, capDb8}, {24'h0, p8.db});
        checkOutput("eWidth8", int'((fallT8 - riseT8) / CLK_P), p8.width);
      end
    end
  end

  // Read monitor: tracks read data phases and checks HRDATA as they complete
  logic dpRd, dpRd8;
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dpRd  <= 1'b0;
      dpRd8 <= 1'b0;
    end else if (HREADY) begin
      dpRd  <= (sel4 | sel8) & HTRANS[1] & !HWRITE;
      dpRd8 <= sel8;
    end
  end

  always @(negedge HCLK) begin
    if (HRESETn && dpRd && HREADY) begin
      if (rdExpQ.size() == 0) begin
        checkOutput("unexpectedRead", dpRd8 ? rdata8 : rdata4, 32'hFFFF_FFFF);
      end else begin
        checkOutput(rdNameQ.pop_front(), dpRd8 ? rdata8 : rdata4, rdExpQ.pop_front());
      end
    end
  end

  // One complete AHB transfer: address phase, then data phase until ready
  task automatic applyStimulus(input logic to8, input logic [31:0] addr, input logic wr,
                               input logic [31:0] wdata, output int stalls);
    int guard;
    stalls = 0;
    @(negedge HCLK);
    guard = 0;
    while (!HREADY && guard < 5000) begin
      @(negedge HCLK);
      guard++;
    end
    sel4   = !to8;
    sel8   = to8;
    HADDR  = addr;
    HTRANS = 2'b10;
    HWRITE = wr;
    @(negedge HCLK);
    sel4   = 1'b0;
    sel8   = 1'b0;
    HTRANS = 2'b00;
    HWDATA = wdata;
    while (!HREADY && stalls < 5000) begin
      @(negedge HCLK);
      stalls++;
    end
    if (!HREADY) checkOutput("stallTimeout", {31'h0, HREADY}, 32'h1);
  endtask

  task automatic regWrite(input logic to8, input logic [31:0] addr, input logic [31:0] data);
    int st;
    applyStimulus(to8, addr, 1'b1, data, st);
  endtask

  task automatic regRead(input logic to8, input logic [31:0] addr, input logic [31:0] exp,
                         input string name);
    int st;
    rdExpQ.push_back(exp);
    rdNameQ.push_back(name);
    applyStimulus(to8, addr, 1'b0, 32'h0, st);
  endtask

  // Queue the strobes a byte must produce, then write it
  task automatic lcdByte(input logic to8, input logic isData, input logic [7:0] b,
                         input int minGap, output int stalls);
    pulse_t p;
    if (to8) begin
      p = '{rs: isData, db: b, width: tim8, minGap: minGap};
      expQ8.push_back(p);
    end else begin
      p = '{rs: isData, db: {4'h0, b[7:4]}, width: tim4, minGap: minGap};
      expQ4.push_back(p);
      p = '{rs: isData, db: {4'h0, b[3:0]}, width: tim4, minGap: 2 * tim4};
      expQ4.push_back(p);
    end
    applyStimulus(to8, isData ? 32'h4 : 32'h0, 1'b1, {24'h0, b}, stalls);
  endtask

  task automatic waitFalls(input logic is8, input int target, input int budget);
    int n;
    n = 0;
    while ((is8 ? fall8 : fall4) < target && n < budget) begin
      @(negedge HCLK);
      n++;
    end
    checkAtLeast(is8 ? "pulseCount8" : "pulseCount4", is8 ? fall8 : fall4, target);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  initial begin
    int st;
    int stalledXfers;
    int n;
    sel4 = 0; sel8 = 0; HADDR = 0; HTRANS = 0; HWRITE = 0; HWDATA = 0;
    waitCycles(3);
    HRESETn = 1'b1;

    // Reset state
    checkOutput("resetE", {31'h0, e4}, 32'h0);
    checkOutput("resetRs", {31'h0, rs4}, 32'h0);
    checkOutput("resetRw", {31'h0, rw4}, 32'h0);
    checkOutput("resetDb", {28'h0, db4}, 32'h0);
    checkOutput("resetReady", {31'h0, rdy4}, 32'h1);
    regRead(0, 32'h08, 32'h0000_0002, "statusReset");
    regRead(0, 32'h0C, 32'd50, "timingReset");
    regRead(0, 32'h00, 32'h0, "cmdReadZero");

    // DATA 0x41 at 4 cycles per step
    regWrite(0, 32'h0C, 32'd4);
    tim4 = 4;
    regRead(0, 32'h0C, 32'd4, "timingReadback");
    lcdByte(0, 1'b1, 8'h41, 0, st);
    waitFalls(0, 2, 500);
    regRead(0, 32'h08, 32'h0000_0003, "statusBusyWait");
    waitCycles(tim4 + T_SHORT + 10);
    regRead(0, 32'h08, 32'h0000_0002, "statusIdle1");

    // Clear display followed by data: long settle before the next entry
    lcdByte(0, 1'b0, 8'h01, 0, st);
    lcdByte(0, 1'b1, 8'h42, T_LONG + tim4, st);
    waitFalls(0, 6, 3000);
    waitCycles(tim4 + T_SHORT + 10);
    regRead(0, 32'h08, 32'h0000_0002, "statusIdle2");

    // Burst of DEPTH+2: first byte drains at once, next DEPTH fill the FIFO
    stalledXfers = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      lcdByte(0, 1'b1, 8'h30 + 8'(i), (i == 0) ? 0 : T_SHORT + tim4, st);
      if (st > 0) stalledXfers++;
    end
    regRead(0, 32'h08, 32'h0008_0005, "statusFull");
    lcdByte(0, 1'b1, 8'h30 + 8'(DEPTH + 1), T_SHORT + tim4, st);
    if (st > 0) stalledXfers++;
    checkOutput("burstStalledXfers", stalledXfers, 32'd1);
    waitFalls(0, 6 + 2 * (DEPTH + 2), 20000);
    waitCycles(tim4 + T_SHORT + 10);
    regRead(0, 32'h08, 32'h0000_0002, "statusIdle3");

    // Reset while E is high for the low nibble
    lcdByte(0, 1'b1, 8'h5A, 0, st);
    n = 0;
    while (rise4 < 2 * (DEPTH + 2) + 6 + 2 && n < 1000) begin
      @(negedge HCLK);
      n++;
    end
    checkOutput("ehlReached", {31'h0, e4}, 32'h1);
    waitCycles(1);
    HRESETn = 1'b0;
    #1;
    checkOutput("midResetE", {31'h0, e4}, 32'h0);
    checkOutput("midResetRs", {31'h0, rs4}, 32'h0);
    checkOutput("midResetDb", {28'h0, db4}, 32'h0);
    waitCycles(2);
    HRESETn = 1'b1;
    tim4 = 50;
    tim8 = 50;
    regRead(0, 32'h08, 32'h0000_0002, "statusAfterReset");
    regRead(0, 32'h0C, 32'd50, "timingAfterReset");

    // 8-bit build: zero step stored as one, single strobe per byte
    regWrite(1, 32'h0C, 32'd0);
    tim8 = 1;
    regRead(1, 32'h0C, 32'd1, "timingZero8");
    lcdByte(1, 1'b1, 8'hA5, 0, st);
    waitFalls(1, 1, 500);
    waitCycles(T_SHORT + 20);
    checkOutput("pulses8", fall8, 32'd1);
    checkOutput("rw8", {31'h0, rw8}, 32'h0);
    regRead(1, 32'h08, 32'h0000_0002, "statusIdle8");

    waitCycles(2);
    checkOutput("leftover4", expQ4.size(), 32'd0);
    checkOutput("leftover8", expQ8.size(), 32'd0);
    checkOutput("leftoverRd", rdExpQ.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #(CLK_P * 90000);
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
